shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//  Upstream controller for the chip74299 universal shift register chain (WIDTH bits).
//  Accepts a shift request (word, amount, direction) and issues the sequence on the mode and serial lines.
//  The sequence is parallel load, then N shift clocks, then readback of IO. Returns the shifted word on a valid/ready response port.
//  Lets the datapath do multi-bit shifts on the discrete shift register without per-cycle control from the sequencer above.
// PARAMETERS
//  WIDTH  8                  data width; must equal the chain width
//  AMT_W  $clog2(WIDTH+1)    shift-amount field width
// PORTS
//  CP         in   1      clock; all state changes on posedge CP
//  MR         in   1      reset, asynchronous, active-high
//  req_valid  in   1      request valid
//  req_ready  out  1      request accepted when req_valid && req_ready at posedge CP
//  req_data   in   WIDTH  word to shift
//  req_amt    in   AMT_W  shift count; values >= WIDTH are clamped to WIDTH
//  req_dir    in   1      0 = right (toward bit 0), 1 = left
//  req_arith  in   1      arithmetic right shift; present only with SHIFT_SEQ_ARITH_EN
//  S          out  2      chain mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load
//  DSR        out  1      serial fill into bit WIDTH-1 on right shift
//  DSL        out  1      serial fill into bit 0 on left shift
//  D_OUT      out  WIDTH  word driven onto chain IO during load
//  D_OE       out  1      1 = D_OUT drives IO
//  N_OE       out  1      chain output enable, active-low; 0 only during READ
//  Q_IN       in   WIDTH  chain IO readback
//  rsp_valid  out  1      result valid
//  rsp_ready  in   1      result consumed when rsp_valid && rsp_ready at posedge CP
//  rsp_data   out  WIDTH  shifted word
// BEHAVIOUR
//  FSM states: IDLE, LOAD, SHIFT, READ, RESP. All outputs are decoded from registered state; no input-to-output comb paths.
//  - IDLE:  req_ready=1, S=00. On accept, latch data, clamped amount into cnt, dir and arith, then go to LOAD.
//  - LOAD:  S=11, D_OE=1, D_OUT=latched data. Lasts 1 cycle. Next state is SHIFT if cnt!=0, else READ.
//  - SHIFT: S=01 (right) or 10 (left). cnt decrements each cycle. On the cycle with cnt==1, go to READ. DSL=0.
//           DSR=0 in this state, except for arithmetic shifts (CONFIGURATION).
//  - READ:  S=00, N_OE=0, D_OE=0. Capture Q_IN into rsp_data at the closing edge, then go to RESP.
//  - RESP:  rsp_valid=1, S=00. Hold rsp_data stable until rsp_ready, then return to IDLE.
//           req_ready=0, so there is no back-to-back overlap.
//  Latency: rsp_valid rises exactly k+2 cycles after the accept edge, where k is the clamped amount. amt=0 gives 2 cycles.
//  Output values outside the states above: D_OE=0, N_OE=1, DSR=DSL=0, D_OUT=0.
//  Reset (MR=1, asynchronous):
//  - state=IDLE, cnt=0, S=00, D_OE=0, N_OE=1, rsp_valid=0, rsp_data=0, DSR=DSL=0.
//  - req_ready is forced 0 while MR is high.
//  - Mid-operation reset aborts with no response. The chain is left holding (S=00), with its contents undefined.
//  A left shift by amt>=WIDTH yields 0. A right shift by amt>=WIDTH yields all fill bits.
//  req_* inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.
// CONFIGURATION
//  SHIFT_SEQ_ARITH_EN defined:
//  - The req_arith port exists and is latched on accept.
//  - For a right shift with arith=1, DSR is driven with latched data[WIDTH-1] through every SHIFT cycle (sign extension).
//  - Left shifts ignore arith.
//  SHIFT_SEQ_ARITH_EN undefined:
//  - The req_arith port is absent and DSR is tied 0. All right shifts are logical.
// STRUCTURE
//  Package shift_seq_pkg:
//  - state_t enum (IDLE, LOAD, SHIFT, READ, RESP).
//  - Mode constants S_HOLD=2'b00, S_SHR=2'b01, S_SHL=2'b10, S_LOAD=2'b11.
//  - Function clamp_amt().
//  One sub-module, shift_seq_ctr: loadable down-counter (AMT_W bits) with async MR and a last (cnt==1) flag.
//  FSM and output decode stay in shift_sequencer.
// TESTING
//  Bench drives a behavioural 74299 chain model on S/DSR/DSL/IO; WIDTH=8.
//  1. Reset: MR pulse mid-SHIFT of 0xA5 by 5 -> S=00, N_OE=1, rsp_valid=0 immediately. Next request completes normally.
//  2. Right shift: data=0xB4, amt=3, dir=0 -> rsp_data=0x16, rsp_valid exactly 5 cycles after accept.
//  3. Left shift and zero: 0x81 left 1 -> 0x02. 0x5A amt=0 -> 0x5A with rsp_valid 2 cycles after accept.
//  4. Clamp: 0xFF amt=12 left -> 0x00, with exactly 8 SHIFT cycles observed on S.
//  5. Backpressure: rsp_ready=0 for 4 cycles -> rsp_data stable, req_ready=0, S=00 throughout, then release.
//  6. SHIFT_SEQ_ARITH_EN:
//     - 0x90 right 2 arith=1 -> 0xE4.
//     - Same with arith=0 -> 0x24.
//     - Macro undefined -> 0x24 regardless.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types, chain mode codes and helpers for the shift sequencer.
// Contents: state_t, S_* mode constants, clamp_amt().
package shift_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    READ,
    RESP
  } state_t;

  localparam logic [1:0] S_HOLD = 2'b00;
  localparam logic [1:0] S_SHR  = 2'b01;
  localparam logic [1:0] S_SHL  = 2'b10;
  localparam logic [1:0] S_LOAD = 2'b11;

  // Shifting a WIDTH-bit chain more than WIDTH times changes nothing further.
  function automatic int unsigned clamp_amt(
    input int unsigned amt,
    input int unsigned width
  );
    return (amt >= width) ? width : amt;
  endfunction

endpackage

// File: rtl/shift_seq_ctr.sv
// Loadable down-counter for remaining shift clocks.
// Ports: CP, MR (async high), load/load_val, dec, cnt, last (cnt==1).
module shift_seq_ctr #(
  parameter int AMT_W = 4
) (
  input  logic             CP,
  input  logic             MR,
  input  logic             load,
  input  logic [AMT_W-1:0] load_val,
  input  logic             dec,
  output logic [AMT_W-1:0] cnt,
  output logic             last
);

  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == AMT_W'(1));

endmodule

// File: rtl/shift_sequencer.sv
// Sequences a 74299 chain: parallel load, N shift clocks, readback.
// Ports: req_* in, rsp_* out, S/DSR/DSL/D_OUT/D_OE/N_OE/Q_IN to chain.
// Optional: SHIFT_SEQ_ARITH_EN adds req_arith (sign-fill right shifts).
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = $clog2(WIDTH + 1)
) (
  input  logic             CP,
  input  logic             MR,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [AMT_W-1:0] req_amt,
  input  logic             req_dir,
`ifdef SHIFT_SEQ_ARITH_EN
  input  logic             req_arith,
`endif
  output logic [1:0]       S,
  output logic             DSR,
  output logic             DSL,
  output logic [WIDTH-1:0] D_OUT,
  output logic             D_OE,
  output logic             N_OE,
  input  logic [WIDTH-1:0] Q_IN,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic             dir_q;
  logic             fill_q;
  logic             accept;
  logic [AMT_W-1:0] amt_c;
  logic [AMT_W-1:0] cnt;
  logic             last;

  assign accept = req_valid && req_ready;
  assign amt_c  = AMT_W'(clamp_amt(32'(req_amt), WIDTH));

  shift_seq_ctr #(
    .AMT_W (AMT_W)
  ) u_ctr (
    .CP       (CP),
    .MR       (MR),
    .load     (accept),
    .load_val (amt_c),
    .dec      (state_q == SHIFT),
    .cnt      (cnt),
    .last     (last)
  );

  always_ff @(posedge CP or posedge MR) begin
    if (MR) begin
      state_q  <= IDLE;
      data_q   <= '0;
      dir_q    <= 1'b0;
      fill_q   <= 1'b0;
      rsp_data <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= req_data;
        dir_q  <= req_dir;
`ifdef SHIFT_SEQ_ARITH_EN
        // Sign fill only matters for right shifts.
        fill_q <= req_arith & ~req_dir & req_data[WIDTH-1];
`else
        fill_q <= 1'b0;
`endif
      end
      if (state_q == READ) begin
        rsp_data <= Q_IN;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = LOAD;
      LOAD:  state_d = (cnt != '0) ? SHIFT : READ;
      SHIFT: if (last) state_d = READ;
      READ:  state_d = RESP;
      RESP:  if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    S         = S_HOLD;
    DSR       = 1'b0;
    DSL       = 1'b0;
    D_OUT     = '0;
    D_OE      = 1'b0;
    N_OE      = 1'b1;
    rsp_valid = 1'b0;
    unique case (state_q)
      IDLE: req_ready = ~MR;
      LOAD: begin
        S     = S_LOAD;
        D_OUT = data_q;
        D_OE  = 1'b1;
      end
      SHIFT: begin
        S   = dir_q ? S_SHL : S_SHR;
        DSR = fill_q;
      end
      READ: N_OE = 1'b0;
      RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer with a behavioural 74299 chain.
// Random and directed requests vs an arithmetic shift reference.
module tb_shift_sequencer;

  localparam int WIDTH = 8;
  localparam int AMT_W = $clog2(WIDTH + 1);

  logic             CP = 1'b0;
  logic             MR = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [WIDTH-1:0] req_data = '0;
  logic [AMT_W-1:0] req_amt = '0;
  logic             req_dir = 1'b0;
  logic             req_arith = 1'b0;
  logic [1:0]       S;
  logic             DSR, DSL;
  logic [WIDTH-1:0] D_OUT;
  logic             D_OE, N_OE;
  logic [WIDTH-1:0] Q_IN;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_data;

  logic [WIDTH-1:0] chain = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CP = ~CP;

  shift_sequencer #(
    .WIDTH (WIDTH)
  ) dut (
    .CP        (CP),
    .MR        (MR),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_amt   (req_amt),
    .req_dir   (req_dir),
`ifdef SHIFT_SEQ_ARITH_EN
    .req_arith (req_arith),
`endif
    .S         (S),
    .DSR       (DSR),
    .DSL       (DSL),
    .D_OUT     (D_OUT),
    .D_OE      (D_OE),
    .N_OE      (N_OE),
    .Q_IN      (Q_IN),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data)
  );

  // Behavioural 74299: IO bus shared between sequencer and chain.
  assign Q_IN = D_OE ? D_OUT : (!N_OE ? chain : '0);

  always @(posedge CP) begin
    case (S)
      2'b11: chain <= Q_IN;
      2'b01: chain <= {DSR, chain[WIDTH-1:1]};
      2'b10: chain <= {chain[WIDTH-2:0], DSL};
      default: chain <= chain;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int clampv(input int a);
    return (a >= WIDTH) ? WIDTH : a;
  endfunction

  function automatic logic arith_eff(input logic ar);
`ifdef SHIFT_SEQ_ARITH_EN
    return ar;
`else
    return 1'b0;
`endif
  endfunction

  // Reference result from plain integer arithmetic.
  function automatic logic [WIDTH-1:0] ref_shift(input int d, input int a,
                                                 input logic dir,
                                                 input logic ar);
    int k, m, r;
    k = clampv(a);
    if (dir) begin
      r = (d << k) & 255;
    end else begin
      m = 255 >> k;
      r = d >> k;
      if (arith_eff(ar) && d >= 128) r = r | (255 & ~m);
    end
    return WIDTH'(r);
  endfunction

  task automatic issue(input logic [7:0] d, input int a, input logic dir,
                       input logic ar);
    int w;
    req_data  = d;
    req_amt   = AMT_W'(a);
    req_dir   = dir;
    req_arith = ar;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      @(posedge CP); #1;
      w++;
    end
    check("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge CP); #1;
    req_valid = 1'b0;
  endtask

  task automatic run_req(input logic [7:0] d, input int a, input logic dir,
                         input logic ar, input int hold);
    int k, lat, shifts;
    logic [1:0] mode;
    logic [7:0] exp, held;
    logic dsr_exp;
    k = clampv(a);
    exp = ref_shift(int'(d), a, dir, ar);
    mode = dir ? 2'b10 : 2'b01;
    dsr_exp = ~dir & arith_eff(ar) & d[7];
    issue(d, a, dir, ar);
    check("load_s", 32'(S), 32'd3);
    check("load_dout", 32'(D_OUT), 32'(d));
    check("load_doe", 32'(D_OE), 32'd1);
    lat = 0;
    shifts = 0;
    while (lat < 40) begin
      @(posedge CP); #1;
      lat++;
      if (rsp_valid) break;
      if (S != 2'b00) begin
        shifts++;
        check("shift_mode", 32'(S), 32'(mode));
        check("shift_dsr", 32'(DSR), 32'(dsr_exp));
        check("shift_dsl", 32'(DSL), 32'd0);
      end
      if (lat == k + 1) check("read_noe", 32'(N_OE), 32'd0);
    end
    check("latency", 32'(lat), 32'(k + 2));
    check("shift_cnt", 32'(shifts), 32'(k));
    check("rsp_data", 32'(rsp_data), 32'(exp));
    check("resp_ready0", 32'(req_ready), 32'd0);
    held = rsp_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge CP); #1;
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_data", 32'(rsp_data), 32'(held));
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_s", 32'(S), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge CP); #1;
    rsp_ready = 1'b0;
    check("rel_valid", 32'(rsp_valid), 32'd0);
    check("rel_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #3;
    check("rst_s", 32'(S), 32'd0);
    check("rst_noe", 32'(N_OE), 32'd1);
    check("rst_doe", 32'(D_OE), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_data", 32'(rsp_data), 32'd0);
    check("rst_dsr_dsl", {30'd0, DSR, DSL}, 32'd0);
    @(posedge CP); #1;
    MR = 1'b0;
    @(posedge CP); #1;

    // Abort mid-SHIFT.
    issue(8'hA5, 5, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge CP); #1;
    end
    check("mid_shift_s", 32'(S), 32'd1);
    MR = 1'b1;
    #1;
    check("abort_s", 32'(S), 32'd0);
    check("abort_noe", 32'(N_OE), 32'd1);
    check("abort_valid", 32'(rsp_valid), 32'd0);
    check("abort_req_ready", 32'(req_ready), 32'd0);
    @(posedge CP); #1;
    MR = 1'b0;
    #1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    run_req(8'hA5, 5, 1'b0, 1'b0, 0);

    run_req(8'hB4, 3, 1'b0, 1'b0, 0);
    run_req(8'h81, 1, 1'b1, 1'b0, 0);
    run_req(8'h5A, 0, 1'b0, 1'b0, 0);
    run_req(8'hFF, 12, 1'b1, 1'b0, 0);
    run_req(8'h3C, 2, 1'b1, 1'b0, 4);
    run_req(8'h90, 2, 1'b0, 1'b1, 0);
    run_req(8'h90, 2, 1'b0, 1'b0, 0);
    run_req(8'h80, 15, 1'b0, 1'b1, 1);
    run_req(8'h7F, 8, 1'b0, 1'b0, 0);

    for (int i = 0; i < 25; i++) begin
      run_req(8'($urandom), int'($urandom_range(0, 15)),
              1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
